alu_exec_unit: RTL and testbench

Parametrised execute stage for the processor datapath: decodes `Funct`/`ALUOp` into ALU control and flag-write enables, computes the ALU result, holds the NZCV flag register, and evaluates the instruction condition field. It generalises the single-cycle ALU decoder with a wider opcode set, a configurable data width, one registered pipeline stage with valid/ready handshake, and conditional execution. It sits between the register-file read stage and write-back.

---
 rtl/alu_pkg.sv | 44 ++++
 rtl/cond_check.sv | 37 +++
 rtl/alu_exec_unit.sv | 117 +++++++++++
 tb/tb_alu_exec_unit.sv | 394 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the execute stage (commands, conditions, ALU functions, NZCV indices)
package alu_pkg;
    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_EOR = 4'b0001;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_TST = 4'b1000;
    localparam logic [3:0] CMD_CMP = 4'b1010;
    localparam logic [3:0] CMD_CMN = 4'b1011;
    localparam logic [3:0] CMD_ORR = 4'b1100;
    localparam logic [3:0] CMD_MOV = 4'b1101;
    localparam logic [3:0] CMD_BIC = 4'b1110;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [2:0] {
        OP_ADD,
        OP_SUB,
        OP_AND,
        OP_ORR,
        OP_EOR,
        OP_BIC,
        OP_MOVB
    } alu_fn_e;
endpackage

// File: rtl/cond_check.sv
// cond_check: evaluates an ARM condition field against the current NZCV flags
module cond_check
    import alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pass
);
    logic n, z, c, v;

    assign n = nzcv[FLAG_N];
    assign z = nzcv[FLAG_Z];
    assign c = nzcv[FLAG_C];
    assign v = nzcv[FLAG_V];

    // Condition truth table; 1110 and 1111 both execute unconditionally
    always_comb begin
        pass = 1'b1;
        case (cond)
            COND_EQ: pass = z;
            COND_NE: pass = !z;
            COND_CS: pass = c;
            COND_CC: pass = !c;
            COND_MI: pass = n;
            COND_PL: pass = !n;
            COND_VS: pass = v;
            COND_VC: pass = !v;
            COND_HI: pass = c && !z;
            COND_LS: pass = !c || z;
            COND_GE: pass = (n == v);
            COND_LT: pass = (n != v);
            COND_GT: pass = !z && (n == v);
            COND_LE: pass = z || (n != v);
            default: pass = 1'b1;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// alu_exec_unit: decode, ALU, NZCV register and conditional execution in one registered stage
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             alu_op,
    input  logic [4:0]       funct,
    input  logic [3:0]       cond,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             reg_write,
    output logic             cond_ex,
    output logic             illegal,
    output logic [3:0]       flags
);
    logic [3:0]       cmd;
    logic             s;
    alu_fn_e          fn;
    logic             wr, ill, pass, accept, sub;
    logic [1:0]       fw;
    logic [WIDTH-1:0] b_eff, alu_out, res;
    logic [WIDTH:0]   sum;
    logic             n, z, c, v;

    assign cmd      = funct[4:1];
    assign s        = funct[0];
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Decode into ALU function, Rd write enable, flag writes {NZ, CV} and illegal marker
    always_comb begin
        fn  = OP_ADD;
        wr  = 1'b1;
        fw  = 2'b00;
        ill = 1'b0;
        if (alu_op) begin
            case (cmd)
                CMD_AND: begin fn = OP_AND;  fw = {s, 1'b0}; end
                CMD_EOR: begin fn = OP_EOR;  fw = {s, 1'b0}; end
                CMD_SUB: begin fn = OP_SUB;  fw = {s, s};    end
                CMD_ADD: begin fn = OP_ADD;  fw = {s, s};    end
                CMD_TST: begin fn = OP_AND;  fw = 2'b10; wr = 1'b0; end
                CMD_CMP: begin fn = OP_SUB;  fw = 2'b11; wr = 1'b0; end
                CMD_CMN: begin fn = OP_ADD;  fw = 2'b11; wr = 1'b0; end
                CMD_ORR: begin fn = OP_ORR;  fw = {s, 1'b0}; end
                CMD_MOV: begin fn = OP_MOVB; fw = {s, 1'b0}; end
                CMD_BIC: begin fn = OP_BIC;  fw = {s, 1'b0}; end
                default: begin wr = 1'b0; ill = 1'b1; end
            endcase
        end
    end

    assign sub   = (fn == OP_SUB);
    assign b_eff = sub ? ~src_b : src_b;
    assign sum   = {1'b0, src_a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};

    // Function select; SUB shares the adder through the inverted operand and carry-in
    always_comb begin
        alu_out = sum[WIDTH-1:0];
        case (fn)
            OP_AND:  alu_out = src_a & src_b;
            OP_ORR:  alu_out = src_a | src_b;
            OP_EOR:  alu_out = src_a ^ src_b;
            OP_BIC:  alu_out = src_a & ~src_b;
            OP_MOVB: alu_out = src_b;
            default: alu_out = sum[WIDTH-1:0];
        endcase
    end

    assign res = ill ? '0 : alu_out;
    assign n   = res[WIDTH-1];
    assign z   = (res == '0);
    assign c   = sum[WIDTH];
    assign v   = (src_a[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != src_a[WIDTH-1]);

    cond_check u_cond (
        .cond (cond),
        .nzcv (flags),
        .pass (pass)
    );

    // Output stage and NZCV update; flags change on the acceptance edge so the next op sees them
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            reg_write <= 1'b0;
            cond_ex   <= 1'b0;
            illegal   <= 1'b0;
            flags     <= 4'b0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= res;
            reg_write <= wr && pass;
            cond_ex   <= pass;
            illegal   <= ill;
            if (pass && fw[1]) begin
                flags[FLAG_N] <= n;
                flags[FLAG_Z] <= z;
            end
            if (pass && fw[0]) begin
                flags[FLAG_C] <= c;
                flags[FLAG_V] <= v;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_exec_unit.sv
// tb_alu_exec_unit: scoreboard bench for the execute stage at WIDTH=32 plus a WIDTH=8 instance
module tb_alu_exec_unit;
    typedef struct packed {
        logic [31:0] result;
        logic        reg_write;
        logic        cond_ex;
        logic        illegal;
        logic [3:0]  flags;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, in_valid, in_ready, alu_op, out_valid, out_ready;
    logic        reg_write, cond_ex, illegal;
    logic [4:0]  funct;
    logic [3:0]  cond, flags;
    logic [31:0] src_a, src_b, result;

    logic        in_valid8, in_ready8, alu_op8, out_valid8, out_ready8;
    logic        reg_write8, cond_ex8, illegal8;
    logic [4:0]  funct8;
    logic [3:0]  cond8, flags8;
    logic [7:0]  src_a8, src_b8, result8;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    exp_t me;
    logic [3:0] mflags;
    logic [3:0] cmds [12] = '{4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b1010,
                              4'b1011, 4'b1100, 4'b1101, 4'b1110, 4'b0011, 4'b1111};

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct(funct), .cond(cond), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .reg_write(reg_write), .cond_ex(cond_ex), .illegal(illegal), .flags(flags)
    );

    alu_exec_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .alu_op(alu_op8), .funct(funct8), .cond(cond8), .src_a(src_a8), .src_b(src_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .reg_write(reg_write8), .cond_ex(cond_ex8), .illegal(illegal8), .flags(flags8)
    );

    // Reference model of one operation against the flags in force at acceptance
    function automatic exp_t model(input logic aop, input logic [4:0] f, input logic [3:0] cnd,
                                   input logic [31:0] a, input logic [31:0] b, input logic [3:0] fl);
        exp_t        e;
        logic [3:0]  cmd;
        logic        s, wr, fnz, fcv, c, v, pass, nf, zf, cf, vf;
        logic [32:0] t;
        logic [31:0] rsub;
        cmd = f[4:1];
        s = f[0];
        wr = 1'b0;
        fnz = 1'b0;
        fcv = 1'b0;
        c = 1'b0;
        v = 1'b0;
        e = '0;
        {nf, zf, cf, vf} = fl;
        case (cnd[3:1])
            3'd0: pass = zf;
            3'd1: pass = cf;
            3'd2: pass = nf;
            3'd3: pass = vf;
            3'd4: pass = cf && !zf;
            3'd5: pass = (nf == vf);
            3'd6: pass = !zf && (nf == vf);
            default: pass = 1'b1;
        endcase
        if (cnd[3:1] != 3'b111) pass = pass ^ cnd[0];
        t = {1'b0, a} + {1'b0, b};
        rsub = a - b;
        if (!aop) begin
            e.result = a + b;
            wr = 1'b1;
        end else begin
            case (cmd)
                4'b0000: begin e.result = a & b; wr = 1'b1; fnz = s; end
                4'b0001: begin e.result = a ^ b; wr = 1'b1; fnz = s; end
                4'b0010, 4'b1010: begin
                    e.result = rsub;
                    c = (a >= b);
                    v = (a[31] != b[31]) && (rsub[31] != a[31]);
                    wr = (cmd == 4'b0010);
                    fnz = s || cmd[3];
                    fcv = s || cmd[3];
                end
                4'b0100, 4'b1011: begin
                    e.result = t[31:0];
                    c = t[32];
                    v = (a[31] == b[31]) && (t[31] != a[31]);
                    wr = (cmd == 4'b0100);
                    fnz = s || cmd[3];
                    fcv = s || cmd[3];
                end
                4'b1000: begin e.result = a & b; fnz = 1'b1; end
                4'b1100: begin e.result = a | b; wr = 1'b1; fnz = s; end
                4'b1101: begin e.result = b; wr = 1'b1; fnz = s; end
                4'b1110: begin e.result = a & ~b; wr = 1'b1; fnz = s; end
                default: e.illegal = 1'b1;
            endcase
        end
        e.reg_write = wr && pass;
        e.cond_ex = pass;
        e.flags = fl;
        if (pass && fnz) e.flags[3:2] = {e.result[31], e.result == 32'h0};
        if (pass && fcv) e.flags[1:0] = {c, v};
        return e;
    endfunction

    // Scoreboard: every output consumed by the downstream handshake is compared against the queue head
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected output res=%h", result);
            end else begin
                me = sb.pop_front();
                if ({result, reg_write, cond_ex, illegal, flags} !== me) begin
                    errors++;
                    $display("FAIL scoreboard: got res=%h rw=%b ce=%b ill=%b nzcv=%b, expected res=%h rw=%b ce=%b ill=%b nzcv=%b",
                             result, reg_write, cond_ex, illegal, flags,
                             me.result, me.reg_write, me.cond_ex, me.illegal, me.flags);
                end
            end
        end
    end

    task automatic send(input logic aop, input logic [4:0] f, input logic [3:0] cnd,
                        input logic [31:0] a, input logic [31:0] b);
        int   n;
        exp_t e;
        in_valid = 1'b1;
        alu_op = aop;
        funct = f;
        cond = cnd;
        src_a = a;
        src_b = b;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL accept: in_ready stayed 0 for %0d cycles, expected 1", n);
        end else begin
            e = model(aop, f, cnd, a, b, mflags);
            mflags = e.flags;
            sb.push_back(e);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (sb.size() != 0 && n < 100);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d results still pending, expected 0", sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, reg_write, cond_ex, illegal, flags} !== {1'b1, 1'b0, 32'h0, 3'b000, 4'b0000}) begin
            errors++;
            $display("FAIL reset: got rdy=%b ov=%b res=%h rw=%b ce=%b ill=%b nzcv=%b, expected 1 0 0 0 0 0 0000",
                     in_ready, out_valid, result, reg_write, cond_ex, illegal, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_subs();
        send(1'b1, 5'b00101, 4'b1110, 32'd5, 32'd5);
        @(negedge clk);
        checks++;
        if ({out_valid, result, reg_write, flags} !== {1'b1, 32'h0, 1'b1, 4'b0110}) begin
            errors++;
            $display("FAIL subs: got ov=%b res=%h rw=%b nzcv=%b, expected 1 0 1 0110", out_valid, result, reg_write, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_overflow_cond();
        send(1'b1, 5'b01001, 4'b1110, 32'h7FFFFFFF, 32'h1);
        send(1'b1, 5'b01001, 4'b1011, 32'h1, 32'h1);
        @(negedge clk);
        checks++;
        if ({cond_ex, reg_write, result, flags} !== {1'b0, 1'b0, 32'h2, 4'b1001}) begin
            errors++;
            $display("FAIL cond_fail: got ce=%b rw=%b res=%h nzcv=%b, expected 0 0 2 1001", cond_ex, reg_write, result, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_cmp_bic();
        send(1'b1, 5'b10100, 4'b1110, 32'd3, 32'd7);
        send(1'b1, 5'b11101, 4'b1110, 32'h800000F0, 32'h000000F0);
        send(1'b1, 5'b10100, 4'b1110, 32'd7, 32'd3);
        send(1'b1, 5'b11101, 4'b1110, 32'h000000FF, 32'h0000000F);
        @(negedge clk);
        checks++;
        if ({result, reg_write, flags} !== {32'h000000F0, 1'b1, 4'b0010}) begin
            errors++;
            $display("FAIL bic_keeps_cv: got res=%h rw=%b nzcv=%b, expected 000000f0 1 0010", result, reg_write, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal();
        send(1'b1, 5'b00111, 4'b1110, 32'd5, 32'd6);
        @(negedge clk);
        checks++;
        if ({illegal, result, reg_write, flags} !== {1'b1, 32'h0, 1'b0, 4'b0010}) begin
            errors++;
            $display("FAIL illegal: got ill=%b res=%h rw=%b nzcv=%b, expected 1 0 0 0010", illegal, result, reg_write, flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall();
        out_ready = 1'b0;
        send(1'b1, 5'b00101, 4'b1110, 32'd10, 32'd20);
        fork
            send(1'b1, 5'b00101, 4'b1110, 32'd5, 32'd5);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checks++;
                    if ({in_ready, out_valid, result, flags} !== {1'b0, 1'b1, 32'hFFFFFFF6, 4'b1000}) begin
                        errors++;
                        $display("FAIL stall_hold: got rdy=%b ov=%b res=%h nzcv=%b, expected 0 1 fffffff6 1000",
                                 in_ready, out_valid, result, flags);
                    end
                end
                @(posedge clk);
                #1 out_ready = 1'b1;
            end
        join
        @(negedge clk);
        checks++;
        if ({out_valid, result, flags} !== {1'b1, 32'h0, 4'b0110}) begin
            errors++;
            $display("FAIL stall_release: got ov=%b res=%h nzcv=%b, expected 1 0 0110", out_valid, result, flags);
        end
        @(posedge clk);
        #1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL out_valid_drop: got %b, expected 0", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back();
        bit done;
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    logic [31:0] a, b;
                    a = $urandom;
                    b = ($urandom_range(0, 3) == 0) ? a : $urandom;
                    send(($urandom_range(0, 5) != 0), {cmds[$urandom_range(0, 11)], 1'($urandom_range(0, 1))},
                         4'($urandom_range(0, 15)), a, b);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk);
                    #1 out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        out_ready = 1'b1;
        drain();
    endtask

    task automatic test_reset_stall();
        out_ready = 1'b0;
        send(1'b1, 5'b00101, 4'b1110, 32'd5, 32'd5);
        reset = 1'b1;
        in_valid = 1'b1;
        alu_op = 1'b1;
        funct = 5'b01001;
        cond = 4'b1110;
        src_a = 32'h7FFFFFFF;
        src_b = 32'h1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, result, reg_write, cond_ex, illegal, flags} !== {1'b0, 32'h0, 3'b000, 4'b0000}) begin
            errors++;
            $display("FAIL reset_stall: got ov=%b res=%h rw=%b ce=%b ill=%b nzcv=%b, expected 0 0 0 0 0 0000",
                     out_valid, result, reg_write, cond_ex, illegal, flags);
        end
        sb.delete();
        mflags = 4'b0000;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_width8();
        in_valid8 = 1'b1;
        alu_op8 = 1'b1;
        funct8 = 5'b01001;
        cond8 = 4'b1110;
        src_a8 = 8'hFF;
        src_b8 = 8'h01;
        @(posedge clk);
        #1;
        src_a8 = 8'h7F;
        @(negedge clk);
        checks++;
        if ({out_valid8, result8, reg_write8, flags8} !== {1'b1, 8'h00, 1'b1, 4'b0110}) begin
            errors++;
            $display("FAIL w8_carry: got ov=%b res=%h rw=%b nzcv=%b, expected 1 00 1 0110", out_valid8, result8, reg_write8, flags8);
        end
        @(posedge clk);
        #1 in_valid8 = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid8, result8, flags8} !== {1'b1, 8'h80, 4'b1001}) begin
            errors++;
            $display("FAIL w8_overflow: got ov=%b res=%h nzcv=%b, expected 1 80 1001", out_valid8, result8, flags8);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        in_valid = 1'b0;
        alu_op = 1'b0;
        funct = '0;
        cond = '0;
        src_a = '0;
        src_b = '0;
        out_ready = 1'b1;
        in_valid8 = 1'b0;
        alu_op8 = 1'b0;
        funct8 = '0;
        cond8 = '0;
        src_a8 = '0;
        src_b8 = '0;
        out_ready8 = 1'b1;
        mflags = 4'b0000;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        test_reset();
        test_subs();
        test_overflow_cond();
        test_cmp_bic();
        test_illegal();
        drain();
        test_stall();
        test_back_to_back();
        test_reset_stall();
        test_width8();
        drain();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
